// File: rtl/mem_xfer_pkg.sv
// mem_xfer_pkg: shared types and constants for the memory-load transfer controller
package mem_xfer_pkg;
  typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, FLUSH} state_e;
  localparam int MAX_XFER_WORDS = 65536;
  function automatic int len_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction
  localparam int LEN_W = len_width(16);
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous clear
// Ports: clk_i/rst_i (async high), clear_i empties, push_i/data_i write,
// pop_i/data_o read head (0 when empty), count_o occupancy, full_o/empty_o flags.
module sync_fifo #(
  parameter int DataWidth = 16,
  parameter int FifoDepth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DataWidth-1:0]         data_i,
  output logic [DataWidth-1:0]         data_o,
  output logic [$clog2(FifoDepth):0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;
  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(FifoDepth);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl: splits a word window into memory bursts and streams the returned words
// Ports: clk_i/rst_i (async high); start_i/abort_i control; mem_upper/start/end_i window;
// mem_req/addr/len_o + mem_gnt_i request side; mem_rvalid/rdata_i read return;
// data/valid_o + ready_i output stream; running/done/error_o status; words_o delivered count.
module mem_xfer_ctrl import mem_xfer_pkg::*; #(
  parameter int DataWidth = 16,
  parameter int MaxBurst  = 16,
  parameter int FifoDepth = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [15:0]                    mem_upper_i,
  input  logic [15:0]                    mem_start_i,
  input  logic [15:0]                    mem_end_i,
  output logic                           mem_req_o,
  output logic [31:0]                    mem_addr_o,
  output logic [len_width(MaxBurst)-1:0] mem_len_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic [DataWidth-1:0]           data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           running_o,
  output logic                           done_o,
  output logic                           error_o,
  output logic [16:0]                    words_o
);
  localparam int LenW = len_width(MaxBurst);
  localparam int CntW = $clog2(FifoDepth) + 1;
  state_e state_q, state_d;
  logic [15:0] upper_q, upper_d, cur_q, cur_d;
  logic [16:0] rem_q, rem_d, words_q, words_d;
  logic [LenW-1:0] out_q, out_d, len;
  logic done_q, done_d, err_q, err_d;
  logic [CntW-1:0] fifo_cnt;
  logic fifo_full, fifo_empty, push, pop, clear, gnt;
  assign len = (rem_q >= 17'(MaxBurst)) ? LenW'(MaxBurst) : LenW'(rem_q);
  // a burst is only requested once the buffer can absorb all of it, so the memory side never stalls
  assign mem_req_o  = state_q == REQ && !fifo_full && (32'(FifoDepth) - 32'(fifo_cnt) >= 32'(len));
  assign mem_addr_o = {upper_q, cur_q};
  assign mem_len_o  = len;
  assign gnt        = mem_req_o && mem_gnt_i;
  assign valid_o    = !fifo_empty;
  assign pop        = valid_o && ready_i;
  assign push       = state_q == DATA && mem_rvalid_i && !abort_i;
  assign clear      = abort_i && state_q inside {REQ, DATA, DRAIN};
  assign running_o  = state_q != IDLE;
  assign done_o     = done_q;
  assign error_o    = err_q;
  assign words_o    = words_q;
  sync_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(clear),
    .push_i (push),
    .pop_i  (pop),
    .data_i (mem_rdata_i),
    .data_o (data_o),
    .count_o(fifo_cnt),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
  always_comb begin
    state_d = state_q;
    upper_d = upper_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    out_d   = out_q;
    words_d = words_q + 17'(pop);
    done_d  = 1'b0;
    err_d   = mem_rvalid_i && state_q inside {IDLE, REQ, DRAIN};
    case (state_q)
      IDLE: if (start_i) begin
        if (mem_start_i > mem_end_i) err_d = 1'b1;
        else begin
          state_d = REQ;
          upper_d = mem_upper_i;
          cur_d   = mem_start_i;
          rem_d   = {1'b0, mem_end_i} - {1'b0, mem_start_i} + 17'd1;
          words_d = '0;
        end
      end
      // a grant arriving with the abort still owes its words, so they are drained in FLUSH
      REQ: if (gnt) begin
        cur_d   = cur_q + 16'(len);
        rem_d   = rem_q - 17'(len);
        out_d   = len;
        state_d = abort_i ? FLUSH : DATA;
      end else if (abort_i) state_d = IDLE;
      DATA: begin
        out_d = out_q - LenW'(mem_rvalid_i);
        if (out_d == '0) state_d = abort_i ? IDLE : (rem_q != '0 ? REQ : DRAIN);
        else if (abort_i) state_d = FLUSH;
      end
      DRAIN: if (abort_i) state_d = IDLE;
      else if (fifo_empty) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      FLUSH: begin
        out_d = out_q - LenW'(mem_rvalid_i);
        if (out_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      upper_q <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upper_q <= upper_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      words_q <= words_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb_mem_xfer_ctrl: directed table-driven bench for mem_xfer_ctrl with a simple memory responder
module tb_mem_xfer_ctrl;
  logic clk_i, rst_i, start_i, abort_i, ready_i;
  logic [15:0] mem_upper_i, mem_start_i, mem_end_i;
  logic mem_req_o, mem_gnt_i, mem_rvalid_i, valid_o, running_o, done_o, error_o;
  logic [31:0] mem_addr_o;
  logic [4:0] mem_len_o;
  logic [15:0] mem_rdata_i, data_o;
  logic [16:0] words_o;
  logic gnt_a, rv_a, rv_m;
  logic [15:0] rd_a;
  logic [31:0] paddr;
  int pend, sent, n_done, n_err, checks, errors;
  int p0, r0, d0, e0, s0;
  logic [15:0] pops[$];
  logic [31:0] req_addr[$];
  int req_len[$];
  typedef struct {
    logic [15:0] up, st, en;
    bit err;
    int nw, nr;
  } vec_t;
  vec_t vecs[7];

  assign mem_gnt_i    = gnt_a;
  assign mem_rvalid_i = rv_a | rv_m;
  assign mem_rdata_i  = rd_a;

  mem_xfer_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .mem_upper_i(mem_upper_i), .mem_start_i(mem_start_i), .mem_end_i(mem_end_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_len_o(mem_len_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .running_o(running_o), .done_o(done_o), .error_o(error_o), .words_o(words_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] pat(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    gnt_a = 1'b0; rv_a = 1'b0; rd_a = '0; pend = 0; sent = 0; paddr = '0;
    forever begin
      @(negedge clk_i);
      gnt_a = 1'b0;
      rv_a  = 1'b0;
      if (rst_i) pend = 0;
      else if (pend > 0) begin
        rd_a = pat(paddr); paddr = paddr + 32'd1; pend--; rv_a = 1'b1; sent++;
      end else if (mem_req_o) begin
        gnt_a = 1'b1; paddr = mem_addr_o; pend = int'(mem_len_o);
        req_addr.push_back(mem_addr_o); req_len.push_back(int'(mem_len_o));
      end
    end
  end

  initial begin
    n_done = 0; n_err = 0;
    forever begin
      @(negedge clk_i); #3;
      if (!rst_i) begin
        if (valid_o && ready_i) pops.push_back(data_o);
        if (done_o) n_done++;
        if (error_o) n_err++;
      end
    end
  end

  task automatic mark();
    p0 = pops.size(); r0 = req_addr.size(); d0 = n_done; e0 = n_err; s0 = sent;
  endtask

  task automatic do_start(input logic [15:0] up, st, en);
    @(negedge clk_i);
    mark();
    mem_upper_i = up; mem_start_i = st; mem_end_i = en; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #2;
  endtask

  task automatic run_check(input string tag, input logic [15:0] up, st, input int nw, nr);
    int t;
    logic [15:0] a;
    t = 0;
    while (running_o && t < 3000) begin @(negedge clk_i); #2; t++; end
    chk({tag, " timeout"}, 32'(t < 3000), 32'd1);
    repeat (2) @(negedge clk_i);
    #2;
    chk({tag, " pops"}, 32'(pops.size() - p0), 32'(nw));
    for (int k = 0; k < nw && p0 + k < pops.size(); k++) begin
      a = st + 16'(k);
      chk({tag, " data"}, 32'(pops[p0 + k]), 32'(pat({up, a})));
    end
    chk({tag, " words_o"}, 32'(words_o), 32'(nw));
    chk({tag, " reqs"}, 32'(req_addr.size() - r0), 32'(nr));
    for (int b = 0; b < nr && r0 + b < req_addr.size(); b++) begin
      a = st + 16'(16 * b);
      chk({tag, " addr"}, req_addr[r0 + b], {up, a});
      chk({tag, " len"}, 32'(req_len[r0 + b]), 32'((nw - 16 * b) < 16 ? nw - 16 * b : 16));
    end
    chk({tag, " done"}, 32'(n_done - d0), 32'd1);
    chk({tag, " err"}, 32'(n_err - e0), 32'd0);
    chk({tag, " running"}, 32'(running_o), 32'd0);
  endtask

  initial begin
    int t;
    checks = 0; errors = 0;
    vecs[0] = '{16'h0001, 16'h0010, 16'h0012, 1'b0, 3, 1};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0027, 1'b0, 40, 3};
    vecs[2] = '{16'h0000, 16'h0005, 16'h0004, 1'b1, 0, 0};
    vecs[3] = '{16'hABCD, 16'hFFF8, 16'hFFFF, 1'b0, 8, 1};
    vecs[4] = '{16'h0002, 16'h0100, 16'h0100, 1'b0, 1, 1};
    vecs[5] = '{16'h0003, 16'h0000, 16'h000F, 1'b0, 16, 1};
    vecs[6] = '{16'h0003, 16'h0000, 16'h0010, 1'b0, 17, 2};
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1; rv_m = 1'b0;
    mem_upper_i = '0; mem_start_i = '0; mem_end_i = '0;
    #3;
    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst running_o", 32'(running_o), 32'd0);
    chk("rst mem_req_o", 32'(mem_req_o), 32'd0);
    chk("rst words_o", 32'(words_o), 32'd0);
    chk("rst addr_len", {mem_addr_o[26:0], mem_len_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      do_start(vecs[i].up, vecs[i].st, vecs[i].en);
      if (vecs[i].err) begin
        chk("err req", 32'(mem_req_o), 32'd0);
        chk("err running", 32'(running_o), 32'd0);
        repeat (2) @(negedge clk_i);
        #2;
        chk("err pulse", 32'(n_err - e0), 32'd1);
        chk("err no req", 32'(req_addr.size() - r0), 32'd0);
        chk("err no done", 32'(n_done - d0), 32'd0);
      end else begin
        chk("start latency req", 32'(mem_req_o), 32'd1);
        chk("start running", 32'(running_o), 32'd1);
        run_check($sformatf("vec%0d", i), vecs[i].up, vecs[i].st, vecs[i].nw, vecs[i].nr);
      end
    end

    ready_i = 1'b0;
    do_start(16'h0000, 16'h0000, 16'h0027);
    repeat (80) @(negedge clk_i);
    #2;
    chk("stall reqs", 32'(req_addr.size() - r0), 32'd2);
    chk("stall no req", 32'(mem_req_o), 32'd0);
    chk("stall valid", 32'(valid_o), 32'd1);
    @(negedge clk_i);
    ready_i = 1'b1;
    t = 0;
    do begin @(negedge clk_i); #2; t++; end while (!mem_req_o && t < 100);
    chk("stall pops before req3", 32'(pops.size() - p0), 32'd8);
    chk("stall req3 addr", mem_addr_o, 32'h0000_0020);
    chk("stall req3 len", 32'(mem_len_o), 32'd8);
    run_check("stall", 16'h0000, 16'h0000, 40, 3);

    ready_i = 1'b0;
    do_start(16'h0000, 16'h0100, 16'h010F);
    t = 0;
    while (sent - s0 < 5 && t < 100) begin @(negedge clk_i); #2; t++; end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #2;
    chk("abort valid", 32'(valid_o), 32'd0);
    chk("abort flushing", 32'(running_o), 32'd1);
    chk("abort no req", 32'(mem_req_o), 32'd0);
    t = 0;
    while (running_o && t < 100) begin @(negedge clk_i); #2; t++; end
    repeat (3) @(negedge clk_i);
    #2;
    chk("abort swallowed", 32'(sent - s0), 32'd16);
    chk("abort idle", 32'(running_o), 32'd0);
    chk("abort no done", 32'(n_done - d0), 32'd0);
    chk("abort no err", 32'(n_err - e0), 32'd0);
    chk("abort no pops", 32'(pops.size() - p0), 32'd0);
    ready_i = 1'b1;
    do_start(16'h0004, 16'h0200, 16'h0203);
    run_check("after abort", 16'h0004, 16'h0200, 4, 1);

    @(negedge clk_i);
    mark();
    rv_m = 1'b1;
    @(negedge clk_i);
    rv_m = 1'b0;
    repeat (2) @(negedge clk_i);
    #2;
    chk("stray err", 32'(n_err - e0), 32'd1);
    chk("stray running", 32'(running_o), 32'd0);
    chk("stray valid", 32'(valid_o), 32'd0);

    ready_i = 1'b0;
    do_start(16'h0000, 16'h0000, 16'h001F);
    t = 0;
    while (sent - s0 < 4 && t < 100) begin @(negedge clk_i); #2; t++; end
    chk("pre-rst valid", 32'(valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst mid valid", 32'(valid_o), 32'd0);
    chk("rst mid running", 32'(running_o), 32'd0);
    chk("rst mid req", 32'(mem_req_o), 32'd0);
    chk("rst mid data", 32'(data_o), 32'd0);
    chk("rst mid pulses", {30'd0, done_o, error_o}, 32'd0);
    chk("rst mid addr", mem_addr_o, 32'd0);
    chk("rst mid len", 32'(mem_len_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #2;
    chk("post-rst valid", 32'(valid_o), 32'd0);
    chk("post-rst running", 32'(running_o), 32'd0);
    chk("post-rst err", 32'(n_err - e0), 32'd0);
    do_start(16'h0009, 16'h0040, 16'h0045);
    run_check("after rst", 16'h0009, 16'h0040, 6, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
